// File: rtl/cv32e40p_simd_addsub_pipe_pkg.sv
// Shared definitions for the packed SIMD add/sub offload path.
package cv32e40p_simd_addsub_pipe_pkg;

  localparam logic [1:0] VEC_MODE32 = 2'b00;
  localparam logic [1:0] VEC_MODE16 = 2'b10;
  localparam logic [1:0] VEC_MODE8  = 2'b11;

  typedef struct packed {
    logic [3:0] carry;
    logic [3:0] ovf;
  } addsub_flags_t;

  // Index of the quarter slice that holds the MSB of the lane containing 'slice'.
  // Mode 01 is decoded as word mode.
  function automatic logic [1:0] laneTop(input logic [1:0] mode, input logic [1:0] slice);
    if (mode == VEC_MODE8) begin
      return slice;
    end else if (mode == VEC_MODE16) begin
      return {slice[1], 1'b1};
    end else begin
      return 2'd3;
    end
  endfunction

endpackage

// File: rtl/cv32e40p_simd_addsub_pipe_slice.sv
// One quarter-width adder slice; SUB is formed as a + ~b + 1, and the carry-in
// comes either from the neighbouring slice (inside a lane) or from sub_i (lane start).
module cv32e40p_addsub_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  input  logic         chain_i,
  input  logic         carry_chain_i,
  output logic [W-1:0] sum_o,
  output logic         carry_o,
  output logic         ovf_o
);

  logic [W-1:0] bEff;
  logic         carryIn;

  // Slice sum with carry-out and signed overflow as if this slice were the lane MSB.
  always_comb begin
    bEff    = sub_i ? ~b_i : b_i;
    carryIn = chain_i ? carry_chain_i : sub_i;
    {carry_o, sum_o} = {1'b0, a_i} + {1'b0, bEff} + {{W{1'b0}}, carryIn};
    ovf_o = (a_i[W-1] == bEff[W-1]) && (sum_o[W-1] != a_i[W-1]);
  end

endmodule

// File: rtl/cv32e40p_simd_addsub_pipe.sv
// Elastic, pipelined SIMD add/sub unit: word, half or byte lanes with per-lane
// carry/borrow and signed-overflow flags and optional saturation.
module cv32e40p_simd_addsub_pipe
  import cv32e40p_simd_addsub_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4,
  parameter int SAT_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             sub_i,
  input  logic             signed_i,
  input  logic             sat_i,
  input  logic [1:0]       vec_mode_i,
  input  logic [WIDTH-1:0] operand_a_i,
  input  logic [WIDTH-1:0] operand_b_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic [3:0]       carry_o,
  output logic [3:0]       ovf_o,
  output logic             zero_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int SW = WIDTH / 4;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    addsub_flags_t    flags;
    logic             zero;
    logic [TAG_W-1:0] tag;
  } stage_t;

  logic [3:0][SW-1:0] sliceA;
  logic [3:0][SW-1:0] sliceB;
  logic [3:0][SW-1:0] sliceSum;
  logic [3:0][SW-1:0] sliceSat;
  logic [3:0]         sliceCout;
  logic [3:0]         sliceOvf;
  logic [3:0]         sliceCarry;
  logic [3:0]         chainSel;
  logic [3:0]         chainIn;
  logic [3:0]         laneCarry;
  logic [3:0]         laneOvf;
  logic               satOn;
  stage_t             data_d;

  logic [STAGES-1:0]  stageValid;
  logic [STAGES-1:0]  stageReady;
  stage_t             stageData [STAGES];

  assign sliceA  = operand_a_i;
  assign sliceB  = operand_b_i;
  assign chainIn = {sliceCout[2:0], 1'b0};
  assign satOn   = sat_i && (SAT_EN != 0);

  // Carry chain is cut at every lane boundary of the selected element size.
  always_comb begin
    if (vec_mode_i == VEC_MODE8) begin
      chainSel = 4'b0000;
    end else if (vec_mode_i == VEC_MODE16) begin
      chainSel = 4'b1010;
    end else begin
      chainSel = 4'b1110;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_slice
    cv32e40p_addsub_slice #(.W(SW)) u_slice (
      .a_i          (sliceA[i]),
      .b_i          (sliceB[i]),
      .sub_i        (sub_i),
      .chain_i      (chainSel[i]),
      .carry_chain_i(chainIn[i]),
      .sum_o        (sliceSum[i]),
      .carry_o      (sliceCout[i]),
      .ovf_o        (sliceOvf[i])
    );
  end

  // Gather per-lane flags from each lane's top slice; SUB reports borrow, not carry.
  always_comb begin
    sliceCarry = sub_i ? ~sliceCout : sliceCout;
    if (vec_mode_i == VEC_MODE8) begin
      laneCarry = sliceCarry;
      laneOvf   = sliceOvf;
    end else if (vec_mode_i == VEC_MODE16) begin
      laneCarry = {2'b00, sliceCarry[3], sliceCarry[1]};
      laneOvf   = {2'b00, sliceOvf[3], sliceOvf[1]};
    end else begin
      laneCarry = {3'b000, sliceCarry[3]};
      laneOvf   = {3'b000, sliceOvf[3]};
    end
  end

  // Saturation: replace each slice with its share of the lane's clamp value.
  always_comb begin
    logic [1:0] top;
    logic       aNeg;
    top      = 2'd0;
    aNeg     = 1'b0;
    sliceSat = '0;
    for (int s = 0; s < 4; s++) begin
      top  = laneTop(vec_mode_i, 2'(s));
      aNeg = sliceA[top][SW-1];
      if (satOn && signed_i && sliceOvf[top]) begin
        sliceSat[s] = (top == 2'(s)) ? {aNeg, {(SW-1){~aNeg}}} : {SW{~aNeg}};
      end else if (satOn && !signed_i && sliceCarry[top]) begin
        sliceSat[s] = sub_i ? '0 : '1;
      end else begin
        sliceSat[s] = sliceSum[s];
      end
    end
  end

  // Stage-0 payload: final result, pre-saturation flags, zero and tag together.
  always_comb begin
    data_d.result      = sliceSat;
    data_d.flags.carry = laneCarry;
    data_d.flags.ovf   = laneOvf;
    data_d.zero        = (sliceSat == '0);
    data_d.tag         = tag_i;
  end

  // A stage may load when some stage at or after it is empty, or the output is taken.
  always_comb begin
    stageReady = '0;
    for (int k = 0; k < STAGES; k++) begin
      stageReady[k] = out_ready_i;
      for (int j = k; j < STAGES; j++) begin
        if (!stageValid[j]) begin
          stageReady[k] = 1'b1;
        end
      end
    end
  end

  assign in_ready_o = !flush_i && stageReady[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic   valid_q;
    stage_t data_q;
    logic   upValid;
    stage_t upData;

    if (k == 0) begin : g_first
      assign upValid = in_valid_i && in_ready_o;
      assign upData  = data_d;
    end else begin : g_next
      assign upValid = stageValid[k-1];
      assign upData  = stageData[k-1];
    end

    // Stage register: reset clears all, flush drops valid, payload only moves with a valid op.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else if (flush_i) begin
        valid_q <= 1'b0;
      end else if (stageReady[k]) begin
        valid_q <= upValid;
        if (upValid) begin
          data_q <= upData;
        end
      end
    end

    assign stageValid[k] = valid_q;
    assign stageData[k]  = data_q;
  end

  assign out_valid_o = stageValid[STAGES-1];
  assign result_o    = stageData[STAGES-1].result;
  assign carry_o     = stageData[STAGES-1].flags.carry;
  assign ovf_o       = stageData[STAGES-1].flags.ovf;
  assign zero_o      = stageData[STAGES-1].zero;
  assign tag_o       = stageData[STAGES-1].tag;

endmodule

// File: tb/tb_cv32e40p_simd_addsub_pipe.sv
// Self-checking bench: lane-arithmetic reference model with an in-order scoreboard,
// directed literal cases, stall/reset/flush scenarios and a randomized phase.
module tb_cv32e40p_simd_addsub_pipe;
  import cv32e40p_simd_addsub_pipe_pkg::*;

  localparam int STAGES = 2;

  typedef struct {
    logic [31:0] result;
    logic [3:0]  carry;
    logic [3:0]  ovf;
    logic        zero;
    logic [3:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        inValid;
  logic        inReady;
  logic        sub;
  logic        sgn;
  logic        sat;
  logic [1:0]  vecMode;
  logic [31:0] opA;
  logic [31:0] opB;
  logic [3:0]  tagIn;
  logic        outValid;
  logic        outReady;
  logic [31:0] result;
  logic [3:0]  carry;
  logic [3:0]  ovf;
  logic        zero;
  logic [3:0]  tagOut;

  int          checks = 0;
  int          errors = 0;
  exp_t        expQ[$];
  logic [3:0]  seenTags[$];
  logic        stallPrev = 1'b0;
  logic [31:0] heldResult;
  logic [3:0]  heldTag;

  cv32e40p_simd_addsub_pipe #(
    .WIDTH(32), .STAGES(STAGES), .TAG_W(4), .SAT_EN(1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush),
    .in_valid_i (inValid),
    .in_ready_o (inReady),
    .sub_i      (sub),
    .signed_i   (sgn),
    .sat_i      (sat),
    .vec_mode_i (vecMode),
    .operand_a_i(opA),
    .operand_b_i(opB),
    .tag_i      (tagIn),
    .out_valid_o(outValid),
    .out_ready_i(outReady),
    .result_o   (result),
    .carry_o    (carry),
    .ovf_o      (ovf),
    .zero_o     (zero),
    .tag_o      (tagOut)
  );

  always #5 clk = ~clk;

  // Compare helper: every comparison in the bench goes through here.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: per-lane integer arithmetic straight from the lane rules.
  function automatic exp_t model(input logic s, input logic sg, input logic st,
                                 input logic [1:0] mode, input logic [31:0] a,
                                 input logic [31:0] b, input logic [3:0] tg);
    exp_t e;
    int lw;
    int nl;
    longint unsigned mask, ua, ub, r;
    longint sa, sb, sr, maxS, minS;
    logic c, o;
    lw = (mode == 2'b11) ? 8 : (mode == 2'b10) ? 16 : 32;
    nl = 32 / lw;
    mask = (64'd1 << lw) - 64'd1;
    maxS = (longint'(1) << (lw - 1)) - 1;
    minS = -(longint'(1) << (lw - 1));
    e.result = '0;
    e.carry  = '0;
    e.ovf    = '0;
    e.tag    = tg;
    for (int j = 0; j < nl; j++) begin
      ua = (longint'(a) >> (j * lw)) & mask;
      ub = (longint'(b) >> (j * lw)) & mask;
      sa = longint'(ua);
      sb = longint'(ub);
      if (ua > longint'(maxS)) sa = sa - (longint'(1) << lw);
      if (ub > longint'(maxS)) sb = sb - (longint'(1) << lw);
      if (s) begin
        r  = (ua - ub) & mask;
        c  = (ua < ub);
        sr = sa - sb;
      end else begin
        r  = (ua + ub) & mask;
        c  = ((ua + ub) > mask);
        sr = sa + sb;
      end
      o = (sr > maxS) || (sr < minS);
      if (st) begin
        if (sg) begin
          if (o) r = (sa < 0) ? (longint'(minS) & mask) : longint'(maxS);
        end else if (c) begin
          r = s ? 64'd0 : mask;
        end
      end
      e.result = e.result | 32'(r << (j * lw));
      e.carry[j] = c;
      e.ovf[j]   = o;
    end
    e.zero = (e.result == 32'd0);
    return e;
  endfunction

  // Scoreboard process: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst || flush) begin
      if (flush && !rst) checkOutput("flushInReady", 64'(inReady), 64'(0));
      expQ.delete();
      stallPrev = 1'b0;
    end else begin
      if (stallPrev) begin
        checkOutput("stallValid", 64'(outValid), 64'(1));
        checkOutput("stallResult", 64'(result), 64'(heldResult));
        checkOutput("stallTag", 64'(tagOut), 64'(heldTag));
      end
      if (outValid && outReady) begin
        if (expQ.size() == 0) begin
          checkOutput("staleOutput", 64'(outValid), 64'(0));
        end else begin
          e = expQ.pop_front();
          checkOutput("result", 64'(result), 64'(e.result));
          checkOutput("carry", 64'(carry), 64'(e.carry));
          checkOutput("ovf", 64'(ovf), 64'(e.ovf));
          checkOutput("zero", 64'(zero), 64'(e.zero));
          checkOutput("tag", 64'(tagOut), 64'(e.tag));
          seenTags.push_back(tagOut);
        end
      end
      if (inValid && inReady) expQ.push_back(model(sub, sgn, sat, vecMode, opA, opB, tagIn));
      stallPrev  = outValid && !outReady;
      heldResult = result;
      heldTag    = tagOut;
    end
  end

  // Present one op and hold it until accepted; returns just after the accepting edge.
  task automatic applyStimulus(input logic s, input logic sg, input logic st, input logic [1:0] mode,
                               input logic [31:0] a, input logic [31:0] b, input logic [3:0] tg);
    logic accepted;
    accepted = 1'b0;
    sub = s; sgn = sg; sat = st; vecMode = mode; opA = a; opB = b; tagIn = tg;
    inValid = 1'b1;
    for (int n = 0; n < 50 && !accepted; n++) begin
      @(negedge clk);
      if (inReady) accepted = 1'b1;
    end
    if (!accepted) checkOutput("acceptTimeout", 64'(0), 64'(1));
    @(posedge clk);
    #1;
    inValid = 1'b0;
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom % 6)
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'h8080_8080;
      default: return $urandom;
    endcase
  endfunction

  task automatic waitDrain();
    for (int n = 0; n < 50 && expQ.size() != 0; n++) @(posedge clk);
    #1;
    checkOutput("drain", 64'(expQ.size()), 64'(0));
  endtask

  initial begin
    int accepted;
    rst = 1'b1; flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
    sub = 1'b0; sgn = 1'b0; sat = 1'b0; vecMode = VEC_MODE32;
    opA = '0; opB = '0; tagIn = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetValid", 64'(outValid), 64'(0));
    checkOutput("resetResult", 64'(result), 64'(0));
    checkOutput("resetFlags", 64'({carry, ovf, zero, tagOut}), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Word SUB 1-10: borrow, no overflow, visible STAGES-1 edges after acceptance.
    applyStimulus(1'b1, 1'b0, 1'b0, VEC_MODE32, 32'd1, 32'd10, 4'd1);
    checkOutput("t1NotYet", 64'(outValid), 64'(0));
    @(posedge clk); #1;
    checkOutput("t1Valid", 64'(outValid), 64'(1));
    checkOutput("t1Result", 64'(result), 64'h0000_0000_FFFF_FFF7);
    checkOutput("t1Carry", 64'(carry), 64'(4'b0001));
    checkOutput("t1Ovf", 64'(ovf), 64'(4'b0000));
    @(posedge clk); #1;

    // Back-to-back word SUBs: 20 then 0 with zero set, on consecutive cycles.
    applyStimulus(1'b1, 1'b0, 1'b0, VEC_MODE32, 32'd25, 32'd5, 4'd2);
    applyStimulus(1'b1, 1'b0, 1'b0, VEC_MODE32, 32'd0, 32'd0, 4'd3);
    checkOutput("t2Result0", 64'(result), 64'(20));
    checkOutput("t2Zero0", 64'(zero), 64'(0));
    @(posedge clk); #1;
    checkOutput("t2Valid1", 64'(outValid), 64'(1));
    checkOutput("t2Result1", 64'(result), 64'(0));
    checkOutput("t2Zero1", 64'(zero), 64'(1));
    @(posedge clk); #1;

    // Half SUB signed saturating.
    applyStimulus(1'b1, 1'b1, 1'b1, VEC_MODE16, 32'h8000_0005, 32'h0001_0006, 4'd4);
    @(posedge clk); #1;
    checkOutput("t3Result", 64'(result), 64'h0000_0000_8000_FFFF);
    checkOutput("t3Ovf", 64'(ovf), 64'(4'b0010));
    checkOutput("t3Carry", 64'(carry), 64'(4'b0001));

    // Byte ADD unsigned saturating.
    applyStimulus(1'b0, 1'b0, 1'b1, VEC_MODE8, 32'hFF10_8001, 32'h01F0_8001, 4'd5);
    @(posedge clk); #1;
    checkOutput("t4Result", 64'(result), 64'h0000_0000_FFFF_FF02);
    checkOutput("t4Carry", 64'(carry), 64'(4'b1110));
    checkOutput("t4Ovf", 64'(ovf), 64'(4'b0010));
    @(posedge clk); #1;

    // Stalled output: full pipe holds STAGES ops, then releases all in order.
    seenTags.delete();
    outReady = 1'b0;
    accepted = 0;
    sub = 1'b0; sgn = 1'b0; sat = 1'b0; vecMode = VEC_MODE16;
    opA = $urandom; opB = $urandom; tagIn = 4'd0; inValid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (inReady) accepted++;
      @(posedge clk); #1;
      tagIn = 4'(accepted); opA = $urandom; opB = $urandom;
    end
    checkOutput("t5Accepted", 64'(accepted), 64'(STAGES));
    checkOutput("t5InReady", 64'(inReady), 64'(0));
    outReady = 1'b1;
    for (int c = 0; c < 30 && accepted < 4; c++) begin
      @(negedge clk);
      if (inReady) accepted++;
      @(posedge clk); #1;
      tagIn = 4'(accepted); opA = $urandom; opB = $urandom;
    end
    inValid = 1'b0;
    waitDrain();
    checkOutput("t5Count", 64'(seenTags.size()), 64'(4));
    for (int i = 0; i < 4 && i < seenTags.size(); i++) begin
      checkOutput("t5TagOrder", 64'(seenTags[i]), 64'(i));
    end

    // Reset with two ops in flight.
    applyStimulus(1'b0, 1'b0, 1'b0, VEC_MODE32, 32'd7, 32'd8, 4'd9);
    applyStimulus(1'b0, 1'b0, 1'b0, VEC_MODE32, 32'd1, 32'd2, 4'd10);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("t6RstValid", 64'(outValid), 64'(0));
    checkOutput("t6RstResult", 64'(result), 64'(0));
    checkOutput("t6RstFlags", 64'({carry, ovf, zero, tagOut}), 64'(0));
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checkOutput("t6RstQuiet", 64'(outValid), 64'(0));
    end

    // Flush with two ops in flight and a third offered during the flush.
    applyStimulus(1'b1, 1'b1, 1'b0, VEC_MODE8, 32'h1234_5678, 32'h0101_0101, 4'd11);
    applyStimulus(1'b1, 1'b1, 1'b0, VEC_MODE8, 32'h1111_1111, 32'h2222_2222, 4'd12);
    flush = 1'b1;
    inValid = 1'b1; opA = 32'd3; opB = 32'd4; tagIn = 4'd13;
    #1;
    checkOutput("t6FlushReady", 64'(inReady), 64'(0));
    @(posedge clk); #1;
    flush = 1'b0;
    inValid = 1'b0;
    checkOutput("t6FlushValid", 64'(outValid), 64'(0));
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checkOutput("t6FlushQuiet", 64'(outValid), 64'(0));
    end

    // Randomized traffic with random backpressure and rare flushes.
    for (int c = 0; c < 600; c++) begin
      inValid  = ($urandom % 4) != 0;
      outReady = ($urandom % 4) != 0;
      flush    = ($urandom % 64) == 0;
      sub      = 1'($urandom);
      sgn      = 1'($urandom);
      sat      = 1'($urandom);
      vecMode  = 2'($urandom);
      opA      = pickOperand();
      opB      = pickOperand();
      tagIn    = 4'($urandom);
      @(posedge clk); #1;
    end
    inValid = 1'b0; flush = 1'b0; outReady = 1'b1;
    waitDrain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
